// File: rtl/md5_message_feeder.sv
`timescale 1ns/1ps
// Packs a byte stream into 512-bit little-endian-byte parts for the MD5 wrapper,
// pulses the wrapper reset per message and captures the returned hash.
module md5_message_feeder (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [60:0]  msg_len_bytes,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic         core_rst,
  output logic [511:0] part_in,
  output logic         part_in_ready,
  output logic [63:0]  total_data_length,
  input  logic         ready_for_next_part,
  input  logic [127:0] hash,
  input  logic         hash_valid,
  output logic [127:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    FILL      = 3'd2,
    WAIT_RDY  = 3'd3,
    OFFER     = 3'd4,
    HOLD      = 3'd5,
    DONE_WAIT = 3'd6
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [60:0]  remaining;
  logic [5:0]   idx;
  logic         accept;

  assign byte_ready = (state == FILL);
  assign accept     = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = CLEAR;
      CLEAR:     state_next = (remaining == 61'd0) ? WAIT_RDY : FILL;
      // A block closes on its 64th byte or on the last byte of the message.
      FILL:      if (accept && (idx == 6'd63 || remaining == 61'd1)) state_next = WAIT_RDY;
      WAIT_RDY:  if (ready_for_next_part) state_next = OFFER;
      OFFER:     state_next = HOLD;
      HOLD:      if (!ready_for_next_part) state_next = (remaining == 61'd0) ? DONE_WAIT : FILL;
      DONE_WAIT: if (hash_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Control strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rst          <= 1'b0;
      part_in_ready     <= 1'b0;
      busy              <= 1'b0;
      digest_valid      <= 1'b0;
      part_in           <= '0;
      total_data_length <= '0;
      digest            <= '0;
      remaining         <= '0;
      idx               <= '0;
    end else begin
      core_rst      <= (state_next == CLEAR);
      part_in_ready <= (state_next == OFFER);
      busy          <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            total_data_length <= {msg_len_bytes, 3'b000};
            remaining         <= msg_len_bytes;
            digest_valid      <= 1'b0;
            part_in           <= '0;
            idx               <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            part_in[{idx, 3'b000} +: 8] <= byte_in;
            idx                         <= idx + 6'd1;
            remaining                   <= remaining - 61'd1;
          end
        end
        HOLD: begin
          if (!ready_for_next_part && remaining != 61'd0) begin
            part_in <= '0;
            idx     <= '0;
          end
        end
        DONE_WAIT: begin
          if (hash_valid) begin
            digest       <= hash;
            digest_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_message_feeder.sv
`timescale 1ns/1ps
// Bench for md5_message_feeder: table of messages plus random ones, checked
// against a byte-array model of how a message splits into 64-byte parts.
module tb_md5_message_feeder;

  logic         clk;
  logic         reset;
  logic         start;
  logic [60:0]  msg_len_bytes;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         core_rst;
  logic [511:0] part_in;
  logic         part_in_ready;
  logic [63:0]  total_data_length;
  logic         ready_for_next_part;
  logic [127:0] hash;
  logic         hash_valid;
  logic [127:0] digest;
  logic         digest_valid;
  logic         busy;

  md5_message_feeder dut (
    .clk(clk), .reset(reset), .start(start), .msg_len_bytes(msg_len_bytes),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .core_rst(core_rst), .part_in(part_in), .part_in_ready(part_in_ready),
    .total_data_length(total_data_length), .ready_for_next_part(ready_for_next_part),
    .hash(hash), .hash_valid(hash_valid), .digest(digest),
    .digest_valid(digest_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] msg [0:255];

  typedef struct {
    int          len;
    int          pattern;    // 0 "abc", 1 counting bytes, 2 random bytes
    int          gap_pct;
    int          rdy_delay;
    bit          poke;
    logic [127:0] h;
    int          exp_parts;
    logic [63:0] exp_tdl;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fill_msg(input int pattern, input int len);
    for (int i = 0; i < 256; i++) begin
      if (pattern == 0) msg[i] = (i < 3) ? 8'h61 + 8'(i) : 8'h00;
      else if (pattern == 1) msg[i] = 8'(i);
      else msg[i] = 8'($urandom);
    end
  endtask

  function automatic logic [511:0] model_part(input int p, input int len);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (64 * p + i < len) r[8*i +: 8] = msg[64 * p + i];
    return r;
  endfunction

  function automatic int model_parts(input int len);
    return (len == 0) ? 1 : (len + 63) / 64;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, 512'(byte_ready), 512'd0);
    chk({tag, "_core_rst"}, 512'(core_rst), 512'd0);
    chk({tag, "_part_in_ready"}, 512'(part_in_ready), 512'd0);
    chk({tag, "_digest_valid"}, 512'(digest_valid), 512'd0);
    chk({tag, "_busy"}, 512'(busy), 512'd0);
    chk({tag, "_part_in"}, part_in, 512'd0);
    chk({tag, "_tdl"}, 512'(total_data_length), 512'd0);
    chk({tag, "_digest"}, 512'(digest), 512'd0);
  endtask

  task automatic run_msg(input int len, input int gap_pct, input int rdy_delay, input bit poke,
                         input logic [127:0] h, input int exp_parts, input logic [63:0] exp_tdl);
    int bi, parts_seen, hold_cnt, rdy_wait, hv_cnt, n_crst;
    bit done, hv_sent, poked;
    logic [511:0] captured;
    bi = 0; parts_seen = 0; hold_cnt = 0; hv_cnt = 0; n_crst = 0;
    done = 0; hv_sent = 0; poked = 0; captured = '0;
    rdy_wait = rdy_delay;
    @(negedge clk);
    start = 1'b1;
    msg_len_bytes = 61'(len);
    byte_valid = 1'b0;
    ready_for_next_part = (rdy_delay == 0);
    for (int cyc = 1; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      hash_valid = 1'b0;
      hash = {4{$urandom}};
      if (core_rst) n_crst++;
      if (cyc == 1) begin
        chk("clear_core_rst", 512'(core_rst), 512'd1);
        chk("clear_byte_ready", 512'(byte_ready), 512'd0);
        chk("start_clears_digest_valid", 512'(digest_valid), 512'd0);
        hash_valid = 1'b1;  // stray result outside DONE_WAIT
      end
      if (cyc == 2 && len > 0) chk("first_byte_ready", 512'(byte_ready), 512'd1);
      if (hv_sent) begin
        chk("digest", 512'(digest), 512'(h));
        chk("digest_valid", 512'(digest_valid), 512'd1);
        chk("busy_after_digest", 512'(busy), 512'd0);
        done = 1;
        continue;
      end
      if (part_in_ready) begin
        chk("offer_gate_rdy", 512'(ready_for_next_part), 512'd1);
        if (parts_seen >= exp_parts) begin
          n_vec++; n_err++;
          $display("FAIL extra_part: got part %0d want only %0d", parts_seen + 1, exp_parts);
        end else begin
          chk($sformatf("part%0d_len%0d", parts_seen, len), part_in, model_part(parts_seen, len));
        end
        chk("total_data_length", 512'(total_data_length), 512'(exp_tdl));
        captured = part_in;
        parts_seen++;
        hold_cnt = 3;
      end else if (hold_cnt > 0) begin
        chk("hold_stable", part_in, captured);
      end
      if (byte_ready) begin
        byte_valid = ($urandom_range(0, 99) >= gap_pct);
        byte_in = msg[bi & 255];
        if (byte_valid) bi++;
      end else begin
        byte_valid = 1'($urandom);
        byte_in = 8'($urandom);
      end
      if (hold_cnt > 0) begin
        hold_cnt--;
        ready_for_next_part = 1'b1;
        if (hold_cnt == 0) begin
          ready_for_next_part = 1'b0;
          rdy_wait = rdy_delay + 1;
          if (parts_seen >= exp_parts) hv_cnt = 3;
        end
      end else if (rdy_wait > 0) begin
        ready_for_next_part = 1'b0;
        rdy_wait--;
      end else begin
        ready_for_next_part = 1'b1;
      end
      if (hv_cnt > 0) begin
        hv_cnt--;
        if (hv_cnt == 0) begin
          chk("digest_valid_before_hash", 512'(digest_valid), 512'd0);
          hash = h;
          hash_valid = 1'b1;
          hv_sent = 1;
        end
      end
      if (poke && !poked && bi == 2) begin
        start = 1'b1;
        msg_len_bytes = 61'd999;
        poked = 1;
      end
    end
    hash_valid = 1'b0;
    byte_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout_len%0d: got %0d parts want %0d", len, parts_seen, exp_parts);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
    end
    chk("bytes_consumed", 512'(bi), 512'(len));
    chk("part_count", 512'(parts_seen), 512'(exp_parts));
    chk("core_rst_pulses", 512'(n_crst), 512'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    msg_len_bytes = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    ready_for_next_part = 1'b0;
    hash = '0;
    hash_valid = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    vecs[0] = '{3,   0, 0,  0,  0, 128'h0123456789abcdeffedcba9876543210, 1, 64'd24};
    vecs[1] = '{100, 1, 0,  0,  0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 64'd800};
    vecs[2] = '{0,   1, 0,  0,  0, 128'hdead_beef_0000_0000_0000_0000_0000_0001, 1, 64'd0};
    vecs[3] = '{64,  1, 0,  0,  0, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 1, 64'd512};
    vecs[4] = '{130, 2, 40, 10, 0, 128'ha5a5_a5a5_5a5a_5a5a_a5a5_a5a5_5a5a_5a5a, 3, 64'd1040};
    vecs[5] = '{3,   0, 0,  10, 0, 128'h0f0f_0f0f_f0f0_f0f0_0f0f_0f0f_f0f0_f0f0, 1, 64'd24};
    vecs[6] = '{70,  2, 20, 2,  1, 128'h1234_5678_9abc_def0_1234_5678_9abc_def0, 2, 64'd560};
    vecs[7] = '{128, 2, 30, 1,  0, 128'hcafe_f00d_cafe_f00d_cafe_f00d_cafe_f00d, 2, 64'd1024};

    for (int v = 0; v < 8; v++) begin
      fill_msg(vecs[v].pattern, vecs[v].len);
      run_msg(vecs[v].len, vecs[v].gap_pct, vecs[v].rdy_delay, vecs[v].poke,
              vecs[v].h, vecs[v].exp_parts, vecs[v].exp_tdl);
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 200);
      fill_msg(2, len);
      run_msg(len, $urandom_range(0, 50), $urandom_range(0, 4), 1'b0, {4{$urandom}},
              model_parts(len), {32'd0, 32'(len)} << 3);
    end

    // Asynchronous reset in the middle of filling a block.
    fill_msg(1, 100);
    @(negedge clk);
    start = 1'b1;
    msg_len_bytes = 61'd100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !byte_ready; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_in = msg[i];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    fill_msg(0, 3);
    run_msg(3, 10, 1, 1'b0, 128'h0123456789abcdeffedcba9876543210, 1, 64'd24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
